// File: rtl/mips_mc_hs.sv
// Multi-cycle MIPS32-subset core with req/ack instruction and data memory ports.
// Optional performance counters are enabled with `define MIPS_MC_HS_PERF_EN.
//
// state  | meaning
// FETCH  | request instruction at PC, latch IR on imem_ack
// DECODE | read rs/rt, extend immediate, arm multiply counter
// EXEC   | ALU op / resolve branch or jump / dispatch LW,SW,BREAK
// MEM    | data access, held until dmem_ack
// WB     | register write, PC += 4, retire
// HALT   | terminal after BREAK, left only by reset
module mips_mc_hs #(
  parameter logic [31:0] PC_INIT    = 32'h0,
  parameter logic [31:0] SP_INIT    = 32'h0,
  parameter logic [31:0] RA_INIT    = 32'h0,
  parameter int unsigned MUL_STAGES = 0
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        retire,
  output logic        halted
`ifdef MIPS_MC_HS_PERF_EN
  ,
  output logic [31:0] cycle_count,
  output logic [31:0] instr_count
`endif
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  localparam logic [2:0] MUL_N = 3'(MUL_STAGES);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, ir_q, ir_d;
  logic [31:0] a_q, a_d, b_q, b_d, imm_q, imm_d, res_q, res_d;
  logic [2:0]  mcnt_q, mcnt_d;
  logic [31:0] rf_q [32];

  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        retire_c;

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm16;
  assign op    = ir_q[31:26];
  assign rs    = ir_q[25:21];
  assign rt    = ir_q[20:16];
  assign rd    = ir_q[15:11];
  assign shamt = ir_q[10:6];
  assign funct = ir_q[5:0];
  assign imm16 = ir_q[15:0];

  logic is_jr, is_brk, is_j, is_jal, is_beq, is_bne, is_lw, is_sw, is_mul;
  assign is_jr  = (op == 6'h00) && (funct == 6'h08);
  assign is_brk = (op == 6'h00) && (funct == 6'h0D);
  assign is_j   = (op == 6'h02);
  assign is_jal = (op == 6'h03);
  assign is_beq = (op == 6'h04);
  assign is_bne = (op == 6'h05);
  assign is_lw  = (op == 6'h23);
  assign is_sw  = (op == 6'h2B);
  assign is_mul = (op == 6'h1C) && (funct == 6'h02);

  logic [31:0] pc_plus4, br_tgt, j_tgt;
  assign pc_plus4 = pc_q + 32'd4;
  assign br_tgt   = pc_plus4 + {imm_q[29:0], 2'b00};
  assign j_tgt    = {pc_plus4[31:28], ir_q[25:0], 2'b00};

  logic [31:0] alu;
  logic        wen;
  logic [4:0]  waddr;

  // Unknown opcodes and functs leave wen low and fall through to WB as a NOP.
  always_comb begin
    alu   = 32'h0;
    wen   = 1'b0;
    waddr = rd;
    case (op)
      6'h00: begin
        wen = 1'b1;
        case (funct)
          6'h00:   alu = b_q << shamt;
          6'h21:   alu = a_q + b_q;
          6'h23:   alu = a_q - b_q;
          6'h24:   alu = a_q & b_q;
          6'h25:   alu = a_q | b_q;
          6'h2A:   alu = {31'b0, $signed(a_q) < $signed(b_q)};
          default: wen = 1'b0;
        endcase
      end
      6'h1C: if (funct == 6'h02) begin alu = a_q * b_q; wen = 1'b1; end
      6'h09: begin alu = a_q + imm_q; wen = 1'b1; waddr = rt; end
      6'h0A: begin alu = {31'b0, $signed(a_q) < $signed(imm_q)}; wen = 1'b1; waddr = rt; end
      6'h0C: begin alu = a_q & imm_q; wen = 1'b1; waddr = rt; end
      6'h0D: begin alu = a_q | imm_q; wen = 1'b1; waddr = rt; end
      6'h0F: begin alu = imm_q; wen = 1'b1; waddr = rt; end
      6'h23: begin alu = a_q + imm_q; wen = 1'b1; waddr = rt; end
      6'h2B: alu = a_q + imm_q;
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    a_d      = a_q;
    b_d      = b_q;
    imm_d    = imm_q;
    res_d    = res_q;
    mcnt_d   = mcnt_q;
    rf_we    = 1'b0;
    rf_waddr = waddr;
    rf_wdata = res_q;
    retire_c = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (imem_ack) begin
          ir_d    = imem_rdata;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        a_d = rf_q[rs];
        b_d = rf_q[rt];
        if (op == 6'h0C || op == 6'h0D) imm_d = {16'h0, imm16};
        else if (op == 6'h0F)           imm_d = {imm16, 16'h0};
        else                            imm_d = {{16{imm16[15]}}, imm16};
        mcnt_d  = MUL_N;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        res_d = alu;
        if (is_mul && mcnt_q != 3'd0) begin
          mcnt_d = mcnt_q - 3'd1;
        end else if (is_beq || is_bne || is_j || is_jal || is_jr) begin
          pc_d = pc_plus4;
          if ((is_beq && a_q == b_q) || (is_bne && a_q != b_q)) pc_d = br_tgt;
          if (is_j || is_jal) pc_d = j_tgt;
          if (is_jr) pc_d = a_q;
          if (is_jal) begin
            rf_we    = 1'b1;
            rf_waddr = 5'd31;
            rf_wdata = pc_plus4;
          end
          retire_c = 1'b1;
          state_d  = S_FETCH;
        end else if (is_lw || is_sw) begin
          state_d = S_MEM;
        end else if (is_brk) begin
          state_d = S_HALT;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        if (dmem_ack) begin
          if (is_lw) begin
            res_d   = dmem_rdata;
            state_d = S_WB;
          end else begin
            pc_d     = pc_plus4;
            retire_c = 1'b1;
            state_d  = S_FETCH;
          end
        end
      end
      S_WB: begin
        rf_we    = wen;
        pc_d     = pc_plus4;
        retire_c = 1'b1;
        state_d  = S_FETCH;
      end
      S_HALT: ;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      pc_q    <= PC_INIT;
      ir_q    <= 32'h0;
      a_q     <= 32'h0;
      b_q     <= 32'h0;
      imm_q   <= 32'h0;
      res_q   <= 32'h0;
      mcnt_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      imm_q   <= imm_d;
      res_q   <= res_d;
      mcnt_q  <= mcnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++)
        rf_q[i] <= (i == 29) ? SP_INIT : (i == 31) ? RA_INIT : 32'h0;
    end else if (rf_we && rf_waddr != 5'd0) begin
      rf_q[rf_waddr] <= rf_wdata;
    end
  end

  // Requests are masked by reset so they drop as soon as reset is sampled.
  assign imem_req   = (state_q == S_FETCH) && !reset;
  assign imem_addr  = pc_q;
  assign dmem_req   = (state_q == S_MEM) && !reset;
  assign dmem_we    = dmem_req && is_sw;
  assign dmem_addr  = res_q;
  assign dmem_wdata = b_q;
  assign retire     = retire_c && !reset;
  assign halted     = (state_q == S_HALT);

`ifdef MIPS_MC_HS_PERF_EN
  logic [31:0] cyc_cnt_q, ins_cnt_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      cyc_cnt_q <= 32'h0;
      ins_cnt_q <= 32'h0;
    end else begin
      if (state_q != S_HALT) cyc_cnt_q <= cyc_cnt_q + 32'd1;
      if (retire_c)          ins_cnt_q <= ins_cnt_q + 32'd1;
    end
  end
  assign cycle_count = cyc_cnt_q;
  assign instr_count = ins_cnt_q;
`endif

endmodule

// File: tb/tb_mips_mc_hs.sv
// Self-checking bench for mips_mc_hs: wait-state memories, scoreboard of fetches,
// data accesses and per-instruction retire latency.
module tb_mips_mc_hs;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_rdata;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        retire, halted;

  always #5 clk = ~clk;

  mips_mc_hs #(
    .PC_INIT(32'h100), .SP_INIT(32'h8000), .RA_INIT(32'h44), .MUL_STAGES(3)
  ) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .retire(retire), .halted(halted)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  logic [31:0] imem [1024];
  logic [31:0] dmem [16384];
  logic [31:0] fq [$];
  logic [31:0] lq [$];
  logic [64:0] aq [$];

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction
  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction
  function automatic logic [31:0] jtype(input logic [5:0] op, input logic [25:0] idx);
    return {op, idx};
  endfunction

  // Expected fetch address and retire latency for an instruction placed in memory.
  task automatic prog(input logic [31:0] a, input logic [31:0] w, input logic [31:0] lat);
    imem[a[11:2]] = w;
    fq.push_back(a);
    if (lat != 0) lq.push_back(lat);
  endtask
  task automatic seq(input logic [31:0] a, input logic [31:0] lat);
    fq.push_back(a);
    lq.push_back(lat);
  endtask
  task automatic acc(input logic we, input logic [31:0] a, input logic [31:0] d);
    aq.push_back({we, a, d});
  endtask
  task automatic sw(input logic [31:0] pc, input logic [4:0] rt, input logic [15:0] off,
                    input logic [31:0] val);
    prog(pc, itype(6'h2B, 5'd0, rt, off), 4);
    acc(1'b1, {16'h0, off}, val);
  endtask

  logic [31:0] cyc = 0;
  always @(posedge clk) cyc <= cyc + 32'd1;

  int          icnt = 0, dcnt = 0;
  logic        ireq_prev = 0, iack_prev = 0, dreq_prev = 0, dack_prev = 0;
  logic [31:0] ihold = 0, dhold = 0, fstart = 0;
  logic [64:0] e;

  // Memory model drives acks at the negedge; checks run 1 time unit later.
  always @(negedge clk) begin
    if (imem_req) begin
      if (icnt == ((imem_addr == 32'h114) ? 3 : 0)) begin
        imem_ack   = 1'b1;
        imem_rdata = imem[imem_addr[11:2]];
        icnt       = 0;
        if (imem_addr == 32'h100) imem[32'h40] = rtype(5'd31, 5'd0, 5'd0, 5'd0, 6'h08);
        if (imem_addr == 32'h200) imem[32'h80] = itype(6'h05, 5'd0, 5'd0, 16'd7);
      end else begin
        imem_ack = 1'b0;
        icnt++;
      end
    end else begin
      imem_ack = 1'b0;
      icnt     = 0;
    end
    if (dmem_req) begin
      if (dcnt == ((dmem_addr == 32'h8008) ? 2 : 0)) begin
        dmem_ack   = 1'b1;
        dmem_rdata = dmem[dmem_addr[15:2]];
        if (dmem_we) dmem[dmem_addr[15:2]] = dmem_wdata;
        dcnt       = 0;
      end else begin
        dmem_ack = 1'b0;
        dcnt++;
      end
    end else begin
      dmem_ack = 1'b0;
      dcnt     = 0;
    end
    #1;
    if (!reset) begin
      if (imem_req && !ireq_prev) begin
        if (fq.size() == 0) chk("fetch_extra", imem_addr, 32'hFFFFFFFF);
        else                chk("fetch_addr", imem_addr, fq.pop_front());
        fstart = cyc;
      end
      if (imem_req && ireq_prev && !iack_prev) chk("imem_addr_hold", imem_addr, ihold);
      if (dmem_req && dreq_prev && !dack_prev) chk("dmem_addr_hold", dmem_addr, dhold);
      if (dmem_req && dmem_ack) begin
        if (aq.size() == 0) chk("dmem_extra", dmem_addr, 32'hFFFFFFFF);
        else begin
          e = aq.pop_front();
          chk("dmem_we", {31'b0, dmem_we}, {31'b0, e[64]});
          chk("dmem_addr", dmem_addr, e[63:32]);
          if (e[64]) chk("dmem_wdata", dmem_wdata, e[31:0]);
        end
      end
      if (retire) begin
        if (lq.size() == 0) chk("retire_extra", 32'd1, 32'd0);
        else                chk("retire_lat", cyc - fstart + 32'd1, lq.pop_front());
      end
    end
    ireq_prev = imem_req;
    iack_prev = imem_ack;
    ihold     = imem_addr;
    dreq_prev = dmem_req;
    dack_prev = dmem_ack;
    dhold     = dmem_addr;
  end

  int nreq;

  initial begin
    reset      = 1'b1;
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    dmem_ack   = 1'b0;
    dmem_rdata = 32'h0;
    for (int i = 0; i < 1024; i++) imem[i] = 32'h0;
    for (int i = 0; i < 16384; i++) dmem[i] = 32'h0;
    dmem[32'h2002] = 32'h12345678;

    sw(32'h100, 5'd29, 16'd0, 32'h8000);
    sw(32'h104, 5'd31, 16'd4, 32'h44);
    prog(32'h108, itype(6'h09, 5'd0, 5'd1, 16'hFFFF), 4);
    prog(32'h10C, rtype(5'd1, 5'd1, 5'd2, 5'd0, 6'h21), 4);
    sw(32'h110, 5'd2, 16'd12, 32'hFFFFFFFE);
    prog(32'h114, itype(6'h23, 5'd29, 5'd3, 16'd8), 10);
    acc(1'b0, 32'h8008, 32'h0);
    sw(32'h118, 5'd3, 16'd16, 32'h12345678);
    prog(32'h11C, jtype(6'h02, 26'h80), 3);
    prog(32'h200, itype(6'h04, 5'd0, 5'd0, 16'hFFFF), 3);
    seq(32'h200, 3);
    prog(32'h204, jtype(6'h02, 26'hC0), 3);
    prog(32'h300, jtype(6'h03, 26'h40), 3);
    seq(32'h100, 3);
    sw(32'h304, 5'd31, 16'd20, 32'h304);
    prog(32'h308, itype(6'h0F, 5'd0, 5'd4, 16'h1), 4);
    prog(32'h30C, {6'h1C, 5'd4, 5'd4, 5'd5, 5'd0, 6'h02}, 7);
    prog(32'h310, {6'h1C, 5'd4, 5'd2, 5'd6, 5'd0, 6'h02}, 7);
    sw(32'h314, 5'd5, 16'd24, 32'h0);
    sw(32'h318, 5'd6, 16'd28, 32'hFFFE0000);
    prog(32'h31C, itype(6'h0D, 5'd0, 5'd7, 16'h8001), 4);
    prog(32'h320, rtype(5'd2, 5'd0, 5'd8, 5'd0, 6'h2A), 4);
    prog(32'h324, itype(6'h0A, 5'd1, 5'd9, 16'd1), 4);
    prog(32'h328, rtype(5'd0, 5'd7, 5'd10, 5'd0, 6'h23), 4);
    prog(32'h32C, rtype(5'd0, 5'd7, 5'd11, 5'd4, 6'h00), 4);
    prog(32'h330, rtype(5'd10, 5'd2, 5'd12, 5'd0, 6'h24), 4);
    prog(32'h334, itype(6'h0C, 5'd1, 5'd13, 16'hFFFF), 4);
    prog(32'h338, rtype(5'd1, 5'd1, 5'd0, 5'd0, 6'h21), 4);
    prog(32'h33C, 32'hFC000000, 4);
    sw(32'h340, 5'd7,  16'd32, 32'h8001);
    sw(32'h344, 5'd8,  16'd36, 32'h1);
    sw(32'h348, 5'd9,  16'd40, 32'h1);
    sw(32'h34C, 5'd10, 16'd44, 32'hFFFF7FFF);
    sw(32'h350, 5'd11, 16'd48, 32'h80010);
    sw(32'h354, 5'd12, 16'd52, 32'hFFFF7FFE);
    sw(32'h358, 5'd13, 16'd56, 32'hFFFF);
    sw(32'h35C, 5'd0,  16'd60, 32'h0);
    prog(32'h360, 32'h0000000D, 0);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_imem_req", {31'b0, imem_req}, 32'd0);
    chk("rst_imem_addr", imem_addr, 32'h100);
    chk("rst_dmem_req", {31'b0, dmem_req}, 32'd0);
    chk("rst_dmem_addr", dmem_addr, 32'h0);
    chk("rst_retire", {31'b0, retire}, 32'd0);
    chk("rst_halted", {31'b0, halted}, 32'd0);
    reset = 1'b0;
    #1;
    chk("post_rst_imem_req", {31'b0, imem_req}, 32'd1);
    chk("post_rst_imem_addr", imem_addr, 32'h100);

    for (int i = 0; i < 3000 && !halted; i++) @(posedge clk);
    #1;
    chk("halted", {31'b0, halted}, 32'd1);
    nreq = 0;
    repeat (20) begin
      @(negedge clk);
      #2;
      if (imem_req || dmem_req) nreq++;
    end
    chk("halt_no_req", 32'(nreq), 32'd0);
    chk("fetch_q_left", 32'(fq.size()), 32'd0);
    chk("retire_q_left", 32'(lq.size()), 32'd0);
    chk("access_q_left", 32'(aq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mips_mc_hs.md
Name: mips_mc_hs

Overview:
- Multi-cycle, non-pipelined MIPS32-subset core; one instruction in flight.
- Drives instruction and data memories over req/ack handshakes, so memories may insert any number of wait states.
- Integrates its own 32x32 register file; R0 is hardwired to zero.
- Successor core for the processor tile: wider ISA, correct MIPS branch arithmetic, configurable multiply latency, halt on BREAK.

Parameters:
- PC_INIT, 32'h0, PC value loaded on reset.
- SP_INIT, 32'h0, R29 value loaded on reset.
- RA_INIT, 32'h0, R31 value loaded on reset.
- MUL_STAGES, 0, extra EXEC cycles for MUL; legal range 0..7.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- imem_req  out  1  instruction fetch request
- imem_addr  out  32  fetch address (current PC)
- imem_ack  in  1  fetch complete; imem_rdata valid this cycle
- imem_rdata  in  32  instruction word
- dmem_req  out  1  data access request
- dmem_we  out  1  1 = store, 0 = load
- dmem_addr  out  32  byte address
- dmem_wdata  out  32  store data
- dmem_ack  in  1  access complete; dmem_rdata valid for loads
- dmem_rdata  in  32  load data
- retire  out  1  one-cycle pulse when an instruction completes
- halted  out  1  high after BREAK until reset

Behaviour:
- Interface: reset reset, synchronous, active-high; clock clk.
- On reset:
  - PC = PC_INIT; R29 = SP_INIT; R31 = RA_INIT; all other registers = 0.
  - State = FETCH.
  - All outputs 0 except imem_addr = PC_INIT. imem_req rises on the first cycle after reset.
- Reset mid-operation: any req drops the cycle after reset is sampled. Memories must be reset together with the core.
- Handshake:
  - req stays high with addr/we/wdata stable until ack is sampled high. req drops the following cycle.
  - Zero-wait memories may assert ack in the same cycle req is first high.
  - ack without req is ignored.
- States and transitions:
  - FETCH: imem_req=1. On imem_ack, latch IR and go to DECODE.
  - DECODE: read rs/rt; sign-extend or zero-extend the immediate. Go to EXEC.
  - EXEC:
    - ALU op. MUL holds EXEC for MUL_STAGES extra cycles.
    - Branches and jumps resolve here: update PC, pulse retire, go to FETCH.
    - LW/SW go to MEM. BREAK sets halted and goes to HALT. All others go to WB.
  - MEM: dmem_req=1, addr = rs + sext(imm). On dmem_ack go to WB (LW) or FETCH with retire (SW).
  - WB: write rd/rt (writes to R0 discarded), PC += 4, pulse retire, go to FETCH.
  - HALT: terminal; no requests issued; exit only via reset.
- Latency with zero-wait memories:
  - ALU ops: 4 cycles (MUL: 4 + MUL_STAGES).
  - LW: 5 cycles. SW: 4 cycles. Branch/jump: 3 cycles.
  - Each wait state adds 1 cycle.
- ISA:
  - SPECIAL: SLL, JR, ADDU, SUBU, AND, OR, SLT, BREAK(001101).
  - SPECIAL2: MUL (low 32 bits of the product).
  - Other opcodes: J, JAL, BEQ, BNE, ADDIU, SLTI, ANDI, ORI (zero-extended immediate), LUI, LW, SW.
  - Unknown opcode or funct executes as NOP: PC += 4, retire pulses.
- Arithmetic:
  - All add/sub wraps modulo 2^32.
  - SLT/SLTI compare signed.
  - Branch target = PC+4 + (sext(imm)<<2); no delay slot.
  - J/JAL target = {PC+4[31:28], idx, 2'b00}. JAL writes PC+4 to R31.
  - PC wraps from 32'hFFFFFFFC to 0.
- Register-file reads during DECODE see all writes from earlier WB cycles.

Optional Feature:
- Macro MIPS_MC_HS_PERF_EN.
- Defined:
  - Adds outputs cycle_count[31:0] and instr_count[31:0], both cleared on reset.
  - cycle_count increments every non-HALT cycle. instr_count increments on each retire.
  - Both wrap at 2^32.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Reset with PC_INIT=32'h100, SP_INIT=32'h8000, RA_INIT=32'h44 -> imem_addr=32'h100 and imem_req=1 on the cycle after reset; readback via SW shows R29=32'h8000, R31=32'h44.
- ADDIU r1,r0,-1 then ADDU r2,r1,r1 with zero-wait memory -> r2=32'hFFFFFFFE; retire pulses 4 cycles apart.
- Insert 3 wait states on the fetch and 2 on the data access of LW r3,8(r29), with SP=32'h8000 -> imem_addr and dmem_addr=32'h8008 held stable while req is high; r3 = loaded value; total 10 cycles.
- BEQ r0,r0,-1 at PC 32'h200 -> next fetch at 32'h200 (self-loop). BNE on equal operands -> next fetch at 32'h204.
- JAL at PC 32'h300 with idx=32'h40 -> next fetch at 32'h100, R31=32'h304; then JR r31 -> next fetch at 32'h304.
- MUL with MUL_STAGES=3 on r=32'h10000 x 32'h10000 -> result 0 (low 32 bits), retire at cycle 7. BREAK -> halted=1, no further imem_req.
